bank_xbar_rr: RTL

Parametrised N-port to N-bank read crossbar for the interleaved on-chip scratchpad. It routes each port's read request to the bank selected by the low address bits. Bank conflicts are resolved per bank by a round-robin arbiter, and losing ports are stalled until granted. Each read is returned to its own port after a configurable memory read latency. It sits between the processing-element read ports and the banked single-port RAMs.

---
 rtl/bank_xbar_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/bank_xbar_rr.sv | 98 +++++++++
 3 files changed

// File: rtl/bank_xbar_pkg.sv
// bank_xbar_pkg: shared sizing defaults and helpers
// for the banked scratchpad read crossbar.
package bank_xbar_pkg;

  localparam int NPORT_DEF = 4;
  localparam int ADDRW_DEF = 16;
  localparam int WL_DEF    = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic logic [31:0] bsel_of(
    input logic [31:0] a,
    input int          w
  );
    return a & ((32'd1 << w) - 32'd1);
  endfunction

  localparam int BSELW_DEF = clog2(NPORT_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, searching
// upward from ptr; ptr moves past the winner on accept.
module rr_arbiter
  import bank_xbar_pkg::*;
#(
  parameter  int N  = NPORT_DEF,
  localparam int PW = clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic          any;

  always_comb begin
    gnt = '0;
    any = 1'b0;
    win = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + PW'(i);
      if (!any && req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
    if (any) gnt[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en && any) begin
      ptr <= win + PW'(1);
    end
  end

endmodule

// File: rtl/bank_xbar_rr.sv
// bank_xbar_rr: N-port to N-bank read crossbar with
// per-bank round-robin and per-port return pipelines.
module bank_xbar_rr
  import bank_xbar_pkg::*;
#(
  parameter  int NPORT  = NPORT_DEF,
  parameter  int ADDRW  = ADDRW_DEF,
  parameter  int WL     = WL_DEF,
  parameter  int RD_LAT = 1,
  localparam int BSELW  = clog2(NPORT),
  localparam int WAW    = ADDRW - BSELW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [NPORT-1:0]       req,
  input  logic [NPORT*ADDRW-1:0] address,
  output logic [NPORT-1:0]       ready,
  output logic [NPORT*WL-1:0]    rdata,
  output logic [NPORT-1:0]       rvalid,
  output logic [NPORT-1:0]       bank_en,
  output logic [NPORT*WAW-1:0]   bank_addr,
  input  logic [NPORT*WL-1:0]    bank_q
);

  logic             act;
  logic [BSELW-1:0] bsel  [NPORT];
  logic [WAW-1:0]   waddr [NPORT];
  logic [NPORT-1:0] breq  [NPORT];
  logic [NPORT-1:0] gnt   [NPORT];

  // Grants are suppressed while frozen or held in reset
  assign act = ena & rst_n;

  for (genvar p = 0; p < NPORT; p++) begin : g_dec
    assign bsel[p] = BSELW'(bsel_of(
      32'(address[p*ADDRW +: ADDRW]), BSELW));
    assign waddr[p] = address[p*ADDRW+BSELW +: WAW];
  end

  always_comb begin
    for (int b = 0; b < NPORT; b++) begin
      breq[b] = '0;
      for (int p = 0; p < NPORT; p++) begin
        breq[b][p] = req[p] && (bsel[p] == BSELW'(b));
      end
    end
  end

  for (genvar b = 0; b < NPORT; b++) begin : g_arb
    rr_arbiter #(.N(NPORT)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (act),
      .req   (breq[b]),
      .gnt   (gnt[b])
    );
  end

  always_comb begin
    ready     = '0;
    bank_en   = '0;
    bank_addr = '0;
    for (int b = 0; b < NPORT; b++) begin
      bank_en[b] = act && (|gnt[b]);
      for (int p = 0; p < NPORT; p++) begin
        if (act && gnt[b][p]) begin
          ready[p] = 1'b1;
          bank_addr[b*WAW +: WAW] = waddr[p];
        end
      end
    end
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_ret
    logic [RD_LAT-1:0] vld;
    logic [BSELW-1:0]  bs [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld <= '0;
        for (int i = 0; i < RD_LAT; i++) bs[i] <= '0;
      end else if (ena) begin
        vld[0] <= ready[p];
        bs[0]  <= bsel[p];
        for (int i = 1; i < RD_LAT; i++) begin
          vld[i] <= vld[i-1];
          bs[i]  <= bs[i-1];
        end
      end
    end

    assign rvalid[p] = vld[RD_LAT-1];
    assign rdata[p*WL +: WL] = vld[RD_LAT-1]
      ? bank_q[bs[RD_LAT-1]*WL +: WL] : '0;
  end

endmodule
